// File: rtl/trb_pkg.sv
// rtl/trb_pkg.sv - trace buffer widths and capture-state encoding shared with the memory controller
package trb_pkg;

  localparam int TRB_ADDR_WIDTH = 8;
  localparam int TRB_WIDTH      = 32;
  localparam int TRB_DEPTH      = 1 << TRB_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_POST   = 3'd2,
    ST_DONE   = 3'd3,
    ST_STREAM = 3'd4
  } trb_state_e;

endpackage

// File: rtl/trb_hold_reg.sv
// rtl/trb_hold_reg.sv - single-entry valid/ready holding register with same-cycle replace
module trb_hold_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept_en,
  input  logic              offer_valid,
  input  logic [DATA_W-1:0] offer_data,
  output logic              ready,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // A popping entry frees the slot in the same cycle, so a new offer can land behind it.
  assign ready = accept_en & (~valid | pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (offer_valid && ready) begin
      valid <= 1'b1;
      data  <= offer_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trb_capture_ctrl.sv
// rtl/trb_capture_ctrl.sv - logger-side capture sequencer: ring capture with post-trigger count, or stream mode
module trb_capture_ctrl
  import trb_pkg::*;
#(
  parameter int ADDR_W = TRB_ADDR_WIDTH,
  parameter int DATA_W = TRB_WIDTH
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              ENABLE_I,
  input  logic              MODE_I,
  input  logic [ADDR_W-1:0] TRG_DELAY_I,
  input  logic              TRACE_VALID_I,
  input  logic [DATA_W-1:0] TRACE_DATA_I,
  output logic              TRACE_READY_O,
  input  logic              TRG_EVENT_I,
  input  logic              RW_TURN_I,
  input  logic              WRITE_ALLOW_I,
  input  logic [ADDR_W-1:0] READ_PTR_I,
  output logic              LOGGER_WRITE_O,
  output logic [ADDR_W-1:0] WRITE_PTR_O,
  output logic [DATA_W-1:0] LOGGER_DATA_O,
  output logic [ADDR_W-1:0] TRG_PTR_O,
  output logic              DONE_O,
  output logic              OVERFLOW_O,
  output logic [15:0]       DROP_COUNT_O,
  output logic [2:0]        STATE_O
);

  trb_state_e        state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_inc, trg_ptr, post_cnt;
  logic              trg_done, overflow;
  logic [15:0]       drop_cnt;
  logic              active_st, accept_en, abort, stream_full, commit, ready, drop, trg_hit;
  logic              hold_valid, hold_clear;
  logic [DATA_W-1:0] hold_data;

  assign active_st   = (state == ST_PRE) || (state == ST_POST) || (state == ST_STREAM);
  assign accept_en   = active_st & ENABLE_I;
  assign abort       = active_st & ~ENABLE_I;
  assign wr_ptr_inc  = wr_ptr + ADDR_W'(1);
  // One slot stays empty so a full ring is distinguishable from an empty one.
  assign stream_full = (state == ST_STREAM) && (wr_ptr_inc == READ_PTR_I);
  assign commit      = hold_valid & ~RW_TURN_I & WRITE_ALLOW_I & accept_en & ~stream_full;
  assign drop        = accept_en & TRACE_VALID_I & ~ready;
  assign trg_hit     = (state == ST_PRE) & ENABLE_I & TRG_EVENT_I;
  assign hold_clear  = (state == ST_IDLE) | abort;

  trb_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk        (CLK_I),
    .rst        (RST_I),
    .clear      (hold_clear),
    .accept_en  (accept_en),
    .offer_valid(TRACE_VALID_I),
    .offer_data (TRACE_DATA_I),
    .ready      (ready),
    .pop        (commit),
    .valid      (hold_valid),
    .data       (hold_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ENABLE_I) state_nxt = MODE_I ? ST_STREAM : ST_PRE;
      ST_PRE: begin
        if (!ENABLE_I)        state_nxt = ST_IDLE;
        else if (TRG_EVENT_I) state_nxt = ST_POST;
      end
      ST_POST: begin
        // First commit in POST is the trigger sample; the rest count down.
        if (!ENABLE_I) state_nxt = ST_IDLE;
        else if (commit && (trg_done ? (post_cnt == ADDR_W'(1)) : (post_cnt == '0)))
          state_nxt = ST_DONE;
      end
      ST_DONE:   if (!ENABLE_I) state_nxt = ST_IDLE;
      ST_STREAM: if (!ENABLE_I) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      trg_ptr  <= '0;
      post_cnt <= '0;
      trg_done <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        wr_ptr   <= '0;
        trg_ptr  <= '0;
        post_cnt <= '0;
        trg_done <= 1'b0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (commit) wr_ptr <= wr_ptr_inc;
        // The trigger sample lands wherever the next write will go after this cycle.
        if (trg_hit) begin
          trg_ptr  <= commit ? wr_ptr_inc : wr_ptr;
          post_cnt <= TRG_DELAY_I;
          trg_done <= 1'b0;
        end
        if ((state == ST_POST) && commit) begin
          if (!trg_done) trg_done <= 1'b1;
          else           post_cnt <= post_cnt - ADDR_W'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  assign TRACE_READY_O  = ready;
  assign LOGGER_WRITE_O = commit;
  assign WRITE_PTR_O    = wr_ptr;
  assign LOGGER_DATA_O  = hold_data;
  assign TRG_PTR_O      = trg_ptr;
  assign DONE_O         = (state == ST_DONE);
  assign OVERFLOW_O     = overflow;
  assign DROP_COUNT_O   = drop_cnt;
  assign STATE_O        = state;

endmodule

// File: tb/tb_trb_capture_ctrl.sv
// tb/tb_trb_capture_ctrl.sv - self-checking bench for trb_capture_ctrl
module tb_trb_capture_ctrl;
  import trb_pkg::*;

  localparam int AW    = TRB_ADDR_WIDTH;
  localparam int DW    = TRB_WIDTH;
  localparam int DEPTH = TRB_DEPTH;

  logic          clk = 1'b0;
  logic          rst, enable, mode, trace_valid, trace_ready, trg_event, rw_turn, write_allow;
  logic [AW-1:0] trg_delay, read_ptr, write_ptr, trg_ptr;
  logic [DW-1:0] trace_data, logger_data;
  logic          logger_write, done, overflow;
  logic [15:0]   drop_count;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  trb_capture_ctrl dut (
    .CLK_I         (clk),
    .RST_I         (rst),
    .ENABLE_I      (enable),
    .MODE_I        (mode),
    .TRG_DELAY_I   (trg_delay),
    .TRACE_VALID_I (trace_valid),
    .TRACE_DATA_I  (trace_data),
    .TRACE_READY_O (trace_ready),
    .TRG_EVENT_I   (trg_event),
    .RW_TURN_I     (rw_turn),
    .WRITE_ALLOW_I (write_allow),
    .READ_PTR_I    (read_ptr),
    .LOGGER_WRITE_O(logger_write),
    .WRITE_PTR_O   (write_ptr),
    .LOGGER_DATA_O (logger_data),
    .TRG_PTR_O     (trg_ptr),
    .DONE_O        (done),
    .OVERFLOW_O    (overflow),
    .DROP_COUNT_O  (drop_count),
    .STATE_O       (state)
  );

  always #5 clk = ~clk;

  // Reference model: buffer state as plain integers and a queue for the holding slot.
  trb_state_e    m_st;
  int            m_wp, m_trg, m_left, m_drops;
  bit            m_ovf, m_trg_written, e_write, e_ready;
  logic [DW-1:0] m_held[$];

  task automatic model_reset();
    m_st = ST_IDLE; m_wp = 0; m_trg = 0; m_left = 0; m_drops = 0;
    m_ovf = 0; m_trg_written = 0; m_held.delete();
  endtask

  task automatic model_eval();
    bit act, full;
    act     = (m_st == ST_PRE || m_st == ST_POST || m_st == ST_STREAM) && enable;
    full    = (m_st == ST_STREAM) && (((m_wp + 1) % DEPTH) == int'(read_ptr));
    e_write = act && (m_held.size() != 0) && !rw_turn && write_allow && !full;
    e_ready = act && ((m_held.size() == 0) || e_write);
  endtask

  task automatic model_advance();
    trb_state_e nxt;
    nxt = m_st;
    if (m_st == ST_IDLE) begin
      m_wp = 0; m_trg = 0; m_drops = 0; m_ovf = 0; m_held.delete();
      if (enable) nxt = mode ? ST_STREAM : ST_PRE;
    end else if (m_st == ST_DONE) begin
      if (!enable) nxt = ST_IDLE;
    end else if (!enable) begin
      m_held.delete();
      nxt = ST_IDLE;
    end else begin
      if (e_write) begin
        void'(m_held.pop_front());
        m_wp = (m_wp + 1) % DEPTH;
        if (m_st == ST_POST) begin
          if (!m_trg_written) m_trg_written = 1;
          else m_left--;
          if (m_trg_written && m_left == 0) nxt = ST_DONE;
        end
      end
      if (trace_valid) begin
        if (e_ready) m_held.push_back(trace_data);
        else begin
          if (m_drops < 65535) m_drops++;
          m_ovf = 1;
        end
      end
      if (m_st == ST_PRE && trg_event) begin
        m_trg = m_wp; m_left = int'(trg_delay); m_trg_written = 0;
        nxt = ST_POST;
      end
    end
    m_st = nxt;
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; mode = 0; trg_delay = '0; trace_valid = 0; trace_data = '0;
    trg_event = 0; rw_turn = 0; write_allow = 1; read_ptr = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
    checks++; if (write_ptr !== '0) begin errors++; $display("FAIL reset_write_ptr got=%0d exp=0", write_ptr); end
    checks++; if (trg_ptr !== '0) begin errors++; $display("FAIL reset_trg_ptr got=%0d exp=0", trg_ptr); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    checks++; if (logger_write !== 1'b0) begin errors++; $display("FAIL reset_logger_write got=%b exp=0", logger_write); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (trace_ready !== 1'b0) begin errors++; $display("FAIL reset_trace_ready got=%b exp=0", trace_ready); end
    checks++; if (logger_data !== '0) begin errors++; $display("FAIL reset_logger_data got=%h exp=0", logger_data); end
    trace_valid = 1;
    repeat (3) @(negedge clk);
    trace_valid = 0;
    #1;
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL idle_offers_ignored got drops=%0d ovf=%b exp drops=0 ovf=0", drop_count, overflow);
    end
  endtask

  task automatic run_capture(input int n, input int trg_at, input int delay,
                             output int wa[$], output int wd[$], output int last_wr, output int done_at);
    wa.delete(); wd.delete(); last_wr = -1; done_at = -1;
    do_reset();
    enable = 1;
    @(negedge clk);
    trg_delay = AW'(delay);
    for (int i = 0; i < n; i++) begin
      trace_valid = 1; trace_data = DW'(i); trg_event = (i == trg_at);
      #1;
      if (logger_write) begin wa.push_back(int'(write_ptr)); wd.push_back(int'(logger_data)); last_wr = i; end
      if (done && done_at < 0) done_at = i;
      @(negedge clk);
    end
    trace_valid = 0; trg_event = 0;
    #1;
  endtask

  task automatic test_capture_trigger();
    int wa[$], wd[$], last_wr, done_at;
    run_capture(30, 9, 4, wa, wd, last_wr, done_at);
    checks++; if (trg_ptr !== AW'(9)) begin errors++; $display("FAIL cap_trg_ptr got=%0d exp=9", trg_ptr); end
    checks++; if (wa.size() != 14) begin errors++; $display("FAIL cap_write_count got=%0d exp=14", wa.size()); end
    for (int k = 0; k < wa.size(); k++) begin
      checks++;
      if (wa[k] != k || wd[k] != k) begin
        errors++; $display("FAIL cap_write_%0d got addr=%0d data=%0d exp addr=%0d data=%0d", k, wa[k], wd[k], k, k);
      end
    end
    checks++; if (done !== 1'b1 || state !== ST_DONE) begin errors++; $display("FAIL cap_done got done=%b state=%0d exp done=1 state=%0d", done, state, ST_DONE); end
    checks++; if (done_at != last_wr + 1) begin errors++; $display("FAIL cap_done_timing got cycle=%0d exp=%0d", done_at, last_wr + 1); end
  endtask

  task automatic test_wrap();
    int wa[$], wd[$], last_wr, done_at;
    run_capture(310, 300, 0, wa, wd, last_wr, done_at);
    checks++; if (trg_ptr !== AW'(44)) begin errors++; $display("FAIL wrap_trg_ptr got=%0d exp=44", trg_ptr); end
    checks++; if (wa.size() != 301) begin errors++; $display("FAIL wrap_write_count got=%0d exp=301", wa.size()); end
    if (wa.size() == 301) begin
      checks++; if (wa[255] != 255 || wa[256] != 0) begin errors++; $display("FAIL wrap_rollover got=%0d,%0d exp=255,0", wa[255], wa[256]); end
      checks++; if (wa[300] != 44 || wd[300] != 300) begin errors++; $display("FAIL wrap_trg_sample got addr=%0d data=%0d exp addr=44 data=300", wa[300], wd[300]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  task automatic test_stream_full();
    int writes;
    writes = 0;
    do_reset();
    mode = 1; enable = 1; read_ptr = '0;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      trace_valid = 1; trace_data = DW'(i);
      #1;
      if (logger_write) writes++;
      @(negedge clk);
    end
    trace_valid = 0;
    #1;
    checks++; if (writes != 255) begin errors++; $display("FAIL stream_writes got=%0d exp=255", writes); end
    checks++; if (write_ptr !== AW'(255)) begin errors++; $display("FAIL stream_write_ptr got=%0d exp=255", write_ptr); end
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd44) begin errors++; $display("FAIL stream_drops got ovf=%b drops=%0d exp ovf=1 drops=44", overflow, drop_count); end
    checks++; if (logger_write !== 1'b0) begin errors++; $display("FAIL stream_stalled got=%b exp=0", logger_write); end
    read_ptr = AW'(100);
    #1;
    checks++; if (logger_write !== 1'b1 || write_ptr !== AW'(255) || logger_data !== DW'(255)) begin
      errors++; $display("FAIL stream_resume got wr=%b addr=%0d data=%0d exp wr=1 addr=255 data=255", logger_write, write_ptr, logger_data);
    end
    @(negedge clk);
  endtask

  task automatic test_turn_toggle();
    int writes;
    writes = 0;
    do_reset();
    enable = 1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      rw_turn = c[0]; trace_valid = 1; trace_data = DW'(c);
      #1;
      if (logger_write) begin
        checks++;
        if (rw_turn !== 1'b0 || logger_data !== DW'(2 * writes)) begin
          errors++; $display("FAIL turn_write_%0d got turn=%b data=%0d exp turn=0 data=%0d", writes, rw_turn, logger_data, 2 * writes);
        end
        writes++;
      end
      @(negedge clk);
    end
    trace_valid = 0; rw_turn = 0;
    #1;
    checks++; if (writes != 9) begin errors++; $display("FAIL turn_write_count got=%0d exp=9", writes); end
    checks++; if (drop_count !== 16'd10 || overflow !== 1'b1) begin errors++; $display("FAIL turn_drops got drops=%0d ovf=%b exp drops=10 ovf=1", drop_count, overflow); end
  endtask

  task automatic test_abort_post();
    do_reset();
    enable = 1;
    @(negedge clk);
    trg_delay = AW'(50);
    for (int i = 0; i < 12; i++) begin
      trace_valid = 1; trace_data = DW'(i); trg_event = (i == 3);
      @(negedge clk);
    end
    trg_event = 0;
    #1;
    checks++; if (state !== ST_POST) begin errors++; $display("FAIL abort_in_post got=%0d exp=%0d", state, ST_POST); end
    enable = 0;
    #1;
    checks++; if (logger_write !== 1'b0) begin errors++; $display("FAIL abort_no_strobe got=%b exp=0", logger_write); end
    @(negedge clk);
    #1;
    checks++; if (state !== ST_IDLE || done !== 1'b0 || trace_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle got state=%0d done=%b ready=%b exp state=%0d done=0 ready=0", state, done, trace_ready, ST_IDLE);
    end
    trace_valid = 0; enable = 1;
    @(negedge clk);
    trace_valid = 1; trace_data = DW'(100);
    @(negedge clk);
    trace_valid = 0;
    #1;
    checks++; if (logger_write !== 1'b1 || write_ptr !== '0 || logger_data !== DW'(100)) begin
      errors++; $display("FAIL rearm_first_write got wr=%b addr=%0d data=%0d exp wr=1 addr=0 data=100", logger_write, write_ptr, logger_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    mode = 1; enable = 1; read_ptr = AW'(5);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1; trace_data = $urandom;
      @(negedge clk);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL midrst_pre_overflow got=%b exp=1", overflow); end
    rst = 1;
    @(negedge clk);
    #1;
    checks++; if (state !== ST_IDLE || write_ptr !== '0 || trg_ptr !== '0 || drop_count !== 16'd0 ||
                  overflow !== 1'b0 || done !== 1'b0 || logger_write !== 1'b0 || trace_ready !== 1'b0 ||
                  logger_data !== '0) begin
      errors++; $display("FAIL midrst_outputs got state=%0d wp=%0d trg=%0d drops=%0d ovf=%b done=%b wr=%b rdy=%b data=%h exp all zero/idle",
                         state, write_ptr, trg_ptr, drop_count, overflow, done, logger_write, trace_ready, logger_data);
    end
    rst = 0; enable = 0; trace_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom_range(0, 99) < 96);
      mode        = 1'($urandom_range(0, 1));
      trg_event   = ($urandom_range(0, 19) == 0);
      trg_delay   = AW'($urandom_range(0, 12));
      trace_valid = ($urandom_range(0, 3) != 0);
      trace_data  = $urandom;
      rw_turn     = ($urandom_range(0, 2) == 0);
      write_allow = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) read_ptr = read_ptr + AW'(1);
      #1;
      model_eval();
      checks++; if (logger_write !== e_write) begin errors++; $display("FAIL rnd_write c=%0d got=%b exp=%b", c, logger_write, e_write); end
      checks++; if (trace_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, trace_ready, e_ready); end
      checks++; if (write_ptr !== AW'(m_wp)) begin errors++; $display("FAIL rnd_write_ptr c=%0d got=%0d exp=%0d", c, write_ptr, m_wp); end
      if (e_write) begin
        checks++; if (logger_data !== m_held[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, logger_data, m_held[0]); end
      end
      checks++; if (state !== m_st) begin errors++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, state, m_st); end
      checks++; if (done !== (m_st == ST_DONE)) begin errors++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, done, m_st == ST_DONE); end
      checks++; if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
        errors++; $display("FAIL rnd_drops c=%0d got ovf=%b drops=%0d exp ovf=%b drops=%0d", c, overflow, drop_count, m_ovf, m_drops);
      end
      checks++; if (trg_ptr !== AW'(m_trg)) begin errors++; $display("FAIL rnd_trg_ptr c=%0d got=%0d exp=%0d", c, trg_ptr, m_trg); end
      model_advance();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_capture_trigger();
    test_wrap();
    test_stream_full();
    test_turn_toggle();
    test_abort_post();
    test_reset_mid_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
